// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: redirect/halt control, imem request/response, head entry and status.
// Latency: none (wiring only); optional perf ports exist when IFQ_PERF_CNT_EN is defined.
// Backpressure: out_valid/out_ready on the head entry; imem side is request-then-fixed-latency data.
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect_in;
  logic [31:0]   redirect_target_in;
  logic          halt_in;
  logic          imem_req_out;
  logic [31:0]   imem_addr_out;
  logic [31:0]   imem_rdata_in;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   pc_out;
  logic [31:0]   pc4_out;
  logic [31:0]   instr_out;
  logic          halt_out;
  logic [CW-1:0] count_out;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0]   fetch_cnt_out;
  logic [31:0]   flush_cnt_out;

  modport master (
    input  redirect_in, redirect_target_in, halt_in, imem_rdata_in, out_ready,
    output imem_req_out, imem_addr_out, out_valid, pc_out, pc4_out, instr_out,
    output halt_out, count_out, fetch_cnt_out, flush_cnt_out
  );
  modport slave (
    output redirect_in, redirect_target_in, halt_in, imem_rdata_in, out_ready,
    input  imem_req_out, imem_addr_out, out_valid, pc_out, pc4_out, instr_out,
    input  halt_out, count_out, fetch_cnt_out, flush_cnt_out
  );
`else
  modport master (
    input  redirect_in, redirect_target_in, halt_in, imem_rdata_in, out_ready,
    output imem_req_out, imem_addr_out, out_valid, pc_out, pc4_out, instr_out,
    output halt_out, count_out
  );
  modport slave (
    output redirect_in, redirect_target_in, halt_in, imem_rdata_in, out_ready,
    input  imem_req_out, imem_addr_out, out_valid, pc_out, pc4_out, instr_out,
    input  halt_out, count_out
  );
`endif
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a DEPTH-entry queue of {PC, instr}; optional perf counters under IFQ_PERF_CNT_EN.
// Latency: head entry valid 2 cycles after a request issues; one request in flight, so >= 1 instr per 2 cycles.
// Backpressure: out_ready stalls pops; requests only issue when queue + in-flight leaves a free slot.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  ifetch_queue_if.master bus
);
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic          r_misalign;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic          w_halt;
  logic          w_aligned;
  logic [CW-1:0] w_occupied;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  // Misalign is sticky and only rst clears it; rst also masks it so halt_out follows halt_in in reset.
  assign w_halt     = bus.halt_in | (r_misalign & ~rst);
  assign w_aligned  = (r_pc[1:0] == 2'b00);
  // Credit: queued entries plus the outstanding response must leave room, so a push never overflows.
  assign w_occupied = r_count + CW'(r_inflight);
  assign w_issue    = ~rst & ~bus.redirect_in & ~w_halt & w_aligned & ~r_inflight &
                      (w_occupied < DEPTH_C);
  // A response arriving in a redirect cycle is stale and is dropped.
  assign w_push     = r_inflight & ~bus.redirect_in;
  assign w_valid    = ~rst & (r_count != '0);
  assign w_pop      = w_valid & bus.out_ready & ~bus.redirect_in;

  // Fetch PC, in-flight tracking, queue pointers/occupancy and the sticky misalign flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (bus.redirect_in) begin
        r_pc       <= bus.redirect_target_in;
        r_inflight <= 1'b0;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_issue) begin
          r_pc     <= r_pc + 32'd4;
          r_req_pc <= r_pc;
        end
        // Issue requires nothing outstanding, so this also retires the response each cycle.
        r_inflight <= w_issue;
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      if (!w_aligned) r_misalign <= 1'b1;
    end
  end

  // Entry storage: the response word is registered here, so instr_out never sees imem_rdata_in directly.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata_in;
    end
  end

  assign bus.imem_req_out  = w_issue;
  assign bus.imem_addr_out = r_pc;
  assign bus.out_valid     = w_valid;
  assign bus.pc_out        = w_valid ? r_pc_mem[r_rd_ptr] : 32'h0;
  assign bus.pc4_out       = w_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : 32'h0;
  assign bus.instr_out     = w_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign bus.halt_out      = w_halt;
  assign bus.count_out     = r_count;

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running wrapping counters of accepted pops and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_pop)           r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (bus.redirect_in) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.fetch_cnt_out = r_fetch_cnt;
  assign bus.flush_cnt_out = r_flush_cnt;
`endif
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 redirect_in  input  1  branch-taken/jump redirect strobe.
REQ-007 redirect_target_in  input  32  redirect PC.
REQ-008 halt_in  input  1  stop issuing new fetches.
REQ-009 imem_req_out  output  1  fetch request this cycle.
REQ-010 imem_addr_out  output  32  fetch address, valid with imem_req_out.
REQ-011 imem_rdata_in  input  32  instruction word, valid the cycle after the request.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  consumer accepts head entry.
REQ-014 pc_out, pc4_out, instr_out  output  32 each  head entry PC, PC+4 and instruction.
REQ-015 halt_out  output  1  fetch halted (halt_in or sticky misalign).
REQ-016 count_out  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 Fetch PC register SHALL issue imem_req_out=1 with imem_addr_out=PC when: no redirect_in, no halt_out, PC[1:0]==0, and count plus in-flight < DEPTH.
REQ-018 On issue, PC SHALL advance by 4 (mod 2^32, wraps from 32'hFFFFFFFC to 0).
REQ-019 At most one request SHALL be in flight; the response cycle pushes {PC, PC+4, imem_rdata_in} at the tail.
REQ-020 Pop SHALL occur when out_valid and out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 The credit rule SHALL guarantee no push when full; out_valid SHALL equal (count != 0).
REQ-022 redirect_in SHALL take priority over push, pop and issue: queue emptied, in-flight response discarded, PC <= redirect_target_in, no request that cycle; issue resumes next cycle.
REQ-023 PC[1:0] != 0 SHALL block issue and set a sticky misalign flag; halt_out = halt_in | sticky flag; the queue continues to drain.
REQ-024 The misalign flag SHALL be cleared only by rst; redirect_in while flagged SHALL still flush and load PC.
REQ-025 halt_in SHALL block new requests only; an in-flight response SHALL still be pushed.
REQ-026 Head outputs SHALL come from registered storage, with zero combinational path from imem_rdata_in to instr_out.
REQ-027 Steady state with out_ready held high SHALL sustain one instruction per two cycles minimum; the first instruction after reset or redirect is valid 2 cycles after issue.

Reset
REQ-028 rst SHALL set PC=RESET_PC, count=0, in-flight=0, misalign flag=0, and counters=0.
REQ-029 During and directly after rst, out_valid=0, imem_req_out=0, halt_out=halt_in, and pc_out/pc4_out/instr_out=0 when empty.
REQ-030 rst asserted mid-operation SHALL discard queued entries and any in-flight response.

Configuration
REQ-031 Macro IFQ_PERF_CNT_EN defined: SHALL add outputs fetch_cnt_out[31:0] (accepted pops) and flush_cnt_out[31:0] (redirects), both wrapping, cleared by rst.
REQ-032 Macro IFQ_PERF_CNT_EN undefined: those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: reset, out_ready=1, memory word(n)=n -> pops PC 0,4,8,C with instr matching and pc4_out=PC+4.
REQ-034 Scenario: out_ready=0 for 20 cycles, DEPTH=4 -> count_out saturates at 4, imem_req_out stops, no entry lost after release.
REQ-035 Scenario: redirect_in to 32'h100 while request in flight and 3 entries queued -> count_out=0 next cycle, stale word never popped, next pop PC=32'h100.
REQ-036 Scenario: redirect to 32'h102 -> no request issued, halt_out=1 and held; queue drains; only rst clears the flag.
REQ-037 Scenario: halt_in pulsed 3 cycles with request in flight -> response pushed, no new requests during the pulse, resume at next PC.
REQ-038 Scenario (IFQ_PERF_CNT_EN): 10 pops and 2 redirects -> fetch_cnt_out=10, flush_cnt_out=2; after rst both read 0.
